poly_horner_pipe: RTL and testbench
===================================

// Module: poly_horner_pipe
// PURPOSE
//  Parametrised pipelined Horner evaluator: y = c0 + x*(c1 + x*(c2 + ... + x*cD)), signed fixed point.
//  Generalises the fixed degree-4, constant-coefficient evaluator. Adds runtime-loadable double-buffered
//  coefficients, valid/ready flow control, selectable saturation and a per-sample overflow flag.
//  Sits between the sample source and the downstream DSP chain.
// PARAMETERS
//  DATA_W    18                      sample/coefficient width, signed two's complement
//  FRAC_W    12                      fractional bits (Q(DATA_W-FRAC_W).FRAC_W)
//  DEGREE    4                       polynomial degree D (>=1); D+1 coefficients
//  SATURATE  1                       1: clamp on overflow; 0: two's-complement wrap
//  COEF_INIT {18'h3f4ab,18'h1ec5,18'h3df43,18'h1cc8,18'h82}  packed cD..c0, reset value of both banks
// PORTS
//  clk        in   1                  clock, all state on rising edge
//  async_n    in   1                  asynchronous active-low reset
//  in_valid   in   1                  x_in valid
//  in_ready   out  1                  block accepts x_in this cycle
//  x_in       in   DATA_W             input sample
//  coef_we    in   1                  write coef_wdata into shadow bank at coef_addr
//  coef_addr  in   $clog2(DEGREE+1)   coefficient index k (c_k)
//  coef_wdata in   DATA_W             coefficient value
//  coef_swap  in   1                  request shadow->active commit
//  busy       out  1                  swap in progress (state != RUN)
//  out_valid  out  1                  y_out/ovf_out valid
//  out_ready  in   1                  downstream accepts
//  y_out      out  DATA_W             result
//  ovf_out    out  1                  1 if any stage of this sample overflowed
// BEHAVIOUR
//  Reset (async_n=0, immediate): all valid bits 0, out_valid=0, y_out=0, ovf_out=0, state=RUN, both banks=COEF_INIT.
//  Pipeline: stage S0 registers x; then D multiply/add pairs; last add register drives y_out. Every stage carries a valid bit, x copy, ovf bit.
//   S0 acc=cD; mult stage: p = (acc*x)[FRAC_W+DATA_W-1:FRAC_W] (arith, truncate toward -inf); add stage: acc = p + c_k, k=D-1..0.
//  Latency: sample accepted on edge E presents on y_out with out_valid=1 after edge E+2*DEGREE (8 for D=4), no stall.
//  Flow: adv = !out_valid | out_ready; all stages advance together only when adv; bubbles travel as valid=0.
//   in_ready = adv & (state==RUN); accept = in_valid & in_ready. y_out/ovf_out held stable while out_valid & !out_ready.
//  Overflow: product slice out of DATA_W signed range, or add carry out -> ovf set, sticky through later stages.
//   SATURATE=1 clamps to 2^(DATA_W-1)-1 / -2^(DATA_W-1); SATURATE=0 keeps low DATA_W bits.
//  Coefficients: coef_we writes shadow[coef_addr] on edge; coef_addr>DEGREE ignored. Pipeline reads active bank only.
//  Swap FSM (each sample uses exactly one coefficient set):
//   RUN  : coef_swap=1 -> DRAIN. A sample accepted in the same cycle uses the old set.
//   DRAIN: in_ready=0; when S0..last-mult valid bits all 0 -> COMMIT (output register may still hold data).
//   COMMIT: in_ready=0; active<=shadow on this edge -> RUN. Writes on this edge land in shadow only.
//   coef_swap outside RUN ignored. Drain stalls with adv=0. Minimum in_ready-low window = 2 cycles.
//  Reset mid-operation discards all in-flight samples and any pending swap; shadow writes lost.
// TESTING
//  1 Defaults, x_in=0x00000 then 0x01000, out_ready=1 -> y_out=0x00082 then 0x00FFD, ovf_out=0, 8 cycles each, back-to-back 1/cycle.
//  2 Stream 20 samples, out_ready toggled random/held 0 for 10 cycles -> in_ready drops while output blocked; outputs in order, none lost/duplicated, vs. golden model.
//  3 Load c0=0x1FFFF, c1=0x01000, others 0, swap, x=0x01000 -> SATURATE=1: y=0x1FFFF ovf=1; SATURATE=0: y=0x20FFF ovf=1.
//  4 Stream in flight, coef_swap with new set -> samples before swap use old set, after use new; busy=1 and in_ready=0 for >=2 cycles.
//  5 Assert async_n=0 mid-stream and mid-DRAIN -> out_valid/y_out/ovf_out 0 at once, banks=COEF_INIT, state RUN after release.
//  6 coef_we with coef_addr=DEGREE+1 then swap, x=0x01000 -> y_out unchanged (0x00FFD).

Source files
------------

// File: rtl/poly_horner_pipe_if.sv
// Stream, coefficient-load and swap signals of the Horner evaluator.
// The slave side is the evaluator and the master side is the source/sink.
interface poly_horner_pipe_if #(
  parameter int DATA_W = 18,
  parameter int DEGREE = 4
);
  localparam int AW = $clog2(DEGREE + 1);

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] x_in;
  logic              coef_we;
  logic [AW-1:0]     coef_addr;
  logic [DATA_W-1:0] coef_wdata;
  logic              coef_swap;
  logic              busy;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] y_out;
  logic              ovf_out;

  modport slave (
    input  in_valid, x_in, coef_we, coef_addr, coef_wdata, coef_swap, out_ready,
    output in_ready, busy, out_valid, y_out, ovf_out
  );

  modport master (
    output in_valid, x_in, coef_we, coef_addr, coef_wdata, coef_swap, out_ready,
    input  in_ready, busy, out_valid, y_out, ovf_out
  );
endinterface

// File: rtl/poly_horner_pipe.sv
// Pipelined signed fixed-point Horner evaluator with double-buffered coefficients.
// It uses one multiply register and one add register per degree, and flow control is a global stall.
module poly_horner_step #(
  parameter int DATA_W   = 18,
  parameter int FRAC_W   = 12,
  parameter bit SATURATE = 1'b1
) (
  input  logic                     clk,
  input  logic                     async_n,
  input  logic                     adv,
  input  logic signed [DATA_W-1:0] x,
  input  logic signed [DATA_W-1:0] coef,
  input  logic signed [DATA_W-1:0] prev_acc,
  input  logic                     prev_ovf,
  output logic signed [DATA_W-1:0] acc,
  output logic                     ovf
);
  localparam int PW = 2 * DATA_W;
  localparam logic signed [DATA_W-1:0] MAXV = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] MINV = ~MAXV;

  logic signed [PW-1:0]     prod, shr;
  logic signed [DATA_W:0]   sum;
  logic signed [DATA_W-1:0] p_q, p_val, s_val;
  logic                     p_ovf, p_ovf_q, s_ovf;

  always_comb begin
    // Sign-extended operands keep the low PW bits equal to the signed product
    prod  = {{DATA_W{prev_acc[DATA_W-1]}}, prev_acc} * {{DATA_W{x[DATA_W-1]}}, x};
    shr   = prod >>> FRAC_W;
    p_ovf = (shr[PW-1:DATA_W-1] != '0) && (shr[PW-1:DATA_W-1] != '1);
    p_val = (SATURATE && p_ovf) ? (shr[PW-1] ? MINV : MAXV) : shr[DATA_W-1:0];
    sum   = {p_q[DATA_W-1], p_q} + {coef[DATA_W-1], coef};
    s_ovf = sum[DATA_W] ^ sum[DATA_W-1];
    s_val = (SATURATE && s_ovf) ? (sum[DATA_W] ? MINV : MAXV) : sum[DATA_W-1:0];
  end

  always_ff @(posedge clk or negedge async_n) begin
    if (!async_n) begin
      p_q     <= '0;
      p_ovf_q <= 1'b0;
      acc     <= '0;
      ovf     <= 1'b0;
    end else if (adv) begin
      p_q     <= p_val;
      p_ovf_q <= prev_ovf | p_ovf;
      acc     <= s_val;
      ovf     <= p_ovf_q | s_ovf;
    end
  end
endmodule

module poly_horner_pipe #(
  parameter int DATA_W   = 18,
  parameter int FRAC_W   = 12,
  parameter int DEGREE   = 4,
  parameter bit SATURATE = 1'b1,
  parameter logic [DATA_W*(DEGREE+1)-1:0] COEF_INIT =
    {18'h3f4ab, 18'h1ec5, 18'h3df43, 18'h1cc8, 18'h82}
) (
  input logic          clk,
  input logic          async_n,
  poly_horner_pipe_if.slave bus
);
  localparam int STAGES = 2 * DEGREE;

  typedef enum logic [1:0] {RUN, DRAIN, COMMIT} state_t;

  state_t                       state;
  logic                         busy_q;
  logic [DEGREE:0][DATA_W-1:0]  active, shadow;
  logic [STAGES:0]              vld_pipe;
  logic [STAGES-2:0][DATA_W-1:0] x_pipe;
  logic [DATA_W-1:0]            s0_acc;
  logic [DEGREE:0][DATA_W-1:0]  acc_c;
  logic [DEGREE:0]              ovf_c;
  logic                         adv, accept;

  assign adv           = !vld_pipe[STAGES] || bus.out_ready;
  assign bus.in_ready  = adv && (state == RUN);
  assign accept        = bus.in_valid && bus.in_ready;
  assign bus.busy      = busy_q;
  assign bus.out_valid = vld_pipe[STAGES];
  assign bus.y_out     = acc_c[DEGREE];
  assign bus.ovf_out   = ovf_c[DEGREE];

  // Commit only once no sample before the final add still needs the active bank
  always_ff @(posedge clk or negedge async_n) begin
    if (!async_n) begin
      state  <= RUN;
      busy_q <= 1'b0;
      active <= COEF_INIT;
      shadow <= COEF_INIT;
    end else begin
      if (bus.coef_we && int'(bus.coef_addr) <= DEGREE)
        shadow[bus.coef_addr] <= bus.coef_wdata;
      case (state)
        RUN: if (bus.coef_swap) begin
          state  <= DRAIN;
          busy_q <= 1'b1;
        end
        DRAIN: if (vld_pipe[STAGES-1:0] == '0) state <= COMMIT;
        COMMIT: begin
          active <= shadow;
          state  <= RUN;
          busy_q <= 1'b0;
        end
        default: begin
          state  <= RUN;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  // S0 plus the x copies that feed each multiply stage
  always_ff @(posedge clk or negedge async_n) begin
    if (!async_n) begin
      vld_pipe <= '0;
      x_pipe   <= '0;
      s0_acc   <= '0;
    end else if (adv) begin
      vld_pipe  <= {vld_pipe[STAGES-1:0], accept};
      x_pipe[0] <= bus.x_in;
      for (int j = 1; j <= STAGES - 2; j++) x_pipe[j] <= x_pipe[j-1];
      s0_acc    <= active[DEGREE];
    end
  end

  assign acc_c[0] = s0_acc;
  assign ovf_c[0] = 1'b0;

  for (genvar i = 1; i <= DEGREE; i++) begin : g_step
    poly_horner_step #(
      .DATA_W  (DATA_W),
      .FRAC_W  (FRAC_W),
      .SATURATE(SATURATE)
    ) u_step (
      .clk     (clk),
      .async_n (async_n),
      .adv     (adv),
      .x       (x_pipe[2*i-2]),
      .coef    (active[DEGREE-i]),
      .prev_acc(acc_c[i-1]),
      .prev_ovf(ovf_c[i-1]),
      .acc     (acc_c[i]),
      .ovf     (ovf_c[i])
    );
  end
endmodule

// File: tb/tb_poly_horner_pipe.sv
// Random and directed stimulus for poly_horner_pipe, scored against an arithmetic Horner model.
module tb_poly_horner_pipe;
  localparam int DATA_W   = 18;
  localparam int FRAC_W   = 12;
  localparam int DEGREE   = 4;
  localparam bit SATURATE = 1'b1;
  localparam int AW       = $clog2(DEGREE + 1);
  localparam logic [DATA_W*(DEGREE+1)-1:0] INIT =
    {18'h3f4ab, 18'h1ec5, 18'h3df43, 18'h1cc8, 18'h82};
  localparam longint MAXL = (longint'(1) <<< (DATA_W - 1)) - 1;
  localparam longint MINL = -(longint'(1) <<< (DATA_W - 1));

  typedef logic [DEGREE:0][DATA_W-1:0] coef_t;
  typedef struct {
    logic [DATA_W-1:0] y;
    logic              ovf;
    int                t;
  } exp_t;

  logic clk = 1'b0;
  logic async_n = 1'b0;
  always #5 clk = ~clk;

  poly_horner_pipe_if #(.DATA_W(DATA_W), .DEGREE(DEGREE)) bus ();

  poly_horner_pipe #(
    .DATA_W(DATA_W), .FRAC_W(FRAC_W), .DEGREE(DEGREE),
    .SATURATE(SATURATE), .COEF_INIT(INIT)
  ) dut (
    .clk(clk), .async_n(async_n), .bus(bus)
  );

  int n_chk = 0, n_pass = 0, n_out = 0, cyc = 0;
  bit lat_chk = 1'b0;
  coef_t m_active = INIT, m_shadow = INIT;
  exp_t sb[$];
  exp_t mon_e;
  logic [DATA_W-1:0] obs_y[$];
  logic obs_ovf[$];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
  endtask

  function automatic longint sx(input logic [DATA_W-1:0] v);
    logic signed [DATA_W-1:0] s;
    s = v;
    return longint'(s);
  endfunction

  // Plain-integer Horner: floor-shifted products, range check after every op
  function automatic exp_t golden(input logic [DATA_W-1:0] x, input coef_t c, input int t);
    longint a, xs;
    bit ov;
    logic [DATA_W-1:0] lo;
    exp_t e;
    xs = sx(x);
    a  = sx(c[DEGREE]);
    ov = 1'b0;
    for (int k = DEGREE - 1; k >= 0; k--) begin
      for (int h = 0; h < 2; h++) begin
        a = (h == 0) ? ((a * xs) >>> FRAC_W) : (a + sx(c[k]));
        if (a > MAXL || a < MINL) begin
          ov = 1'b1;
          lo = a[DATA_W-1:0];
          a  = SATURATE ? ((a > MAXL) ? MAXL : MINL) : sx(lo);
        end
      end
    end
    e.y = a[DATA_W-1:0];
    e.ovf = ov;
    e.t = t;
    return e;
  endfunction

  function automatic logic [DATA_W-1:0] rnd_x();
    int v;
    v = ($urandom_range(0, 3) == 0) ? int'($urandom) : int'($urandom_range(0, 16383)) - 8192;
    return v[DATA_W-1:0];
  endfunction

  function automatic logic [DATA_W-1:0] rnd_c();
    int v;
    v = int'($urandom_range(0, 4095)) - 2048;
    return v[DATA_W-1:0];
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: transfers sampled mid-cycle, model banks follow the bench's own writes/swaps
  always @(negedge clk) begin
    if (!async_n) begin
      sb.delete();
      m_active = INIT;
      m_shadow = INIT;
    end else begin
      if (bus.out_valid && bus.out_ready) begin
        obs_y.push_back(bus.y_out);
        obs_ovf.push_back(bus.ovf_out);
        n_out++;
        if (sb.size() == 0) chk("unexpected_out", 1, 0);
        else begin
          mon_e = sb.pop_front();
          chk("y", bus.y_out, mon_e.y);
          chk("ovf", bus.ovf_out, mon_e.ovf);
          if (lat_chk) chk("latency", cyc - mon_e.t, 2 * DEGREE);
        end
      end
      if (bus.in_valid && bus.in_ready) sb.push_back(golden(bus.x_in, m_active, cyc + 1));
      if (bus.coef_swap) m_active = m_shadow;
      if (bus.coef_we && int'(bus.coef_addr) <= DEGREE) m_shadow[bus.coef_addr] = bus.coef_wdata;
    end
  end

  task automatic align();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [DATA_W-1:0] x);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.x_in = x;
    do begin @(negedge clk); n++; end while (!bus.in_ready && n < 200);
    if (!bus.in_ready) chk("send_timeout", 1, 0);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic write_coef(input logic [AW-1:0] a, input logic [DATA_W-1:0] v);
    align();
    bus.coef_we = 1'b1; bus.coef_addr = a; bus.coef_wdata = v;
    align();
    bus.coef_we = 1'b0;
  endtask

  task automatic pulse_swap();
    align();
    bus.coef_swap = 1'b1;
    align();
    bus.coef_swap = 1'b0;
  endtask

  task automatic do_swap(input string tag);
    int nb, n;
    nb = 0; n = 0;
    pulse_swap();
    forever begin
      @(negedge clk); n++;
      if (!bus.busy || n >= 500) break;
      nb++;
      chk({tag, "_rdy_low"}, bus.in_ready, 0);
    end
    if (bus.busy) chk({tag, "_timeout"}, 1, 0);
    chk({tag, "_len_ge2"}, nb >= 2, 1);
  endtask

  task automatic wait_out(input int target, input string tag);
    int k;
    k = 0;
    while (n_out < target && k < 400) begin @(negedge clk); k++; end
    if (n_out < target) chk({tag, "_out_timeout"}, n_out, target);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int base;
    logic [DATA_W-1:0] hold_y;
    bus.in_valid = 1'b0; bus.x_in = '0; bus.coef_we = 1'b0; bus.coef_addr = '0;
    bus.coef_wdata = '0; bus.coef_swap = 1'b0; bus.out_ready = 1'b1;

    // reset state, then two back-to-back samples with default coefficients
    repeat (3) @(posedge clk);
    #1;
    chk("rst_vld", bus.out_valid, 0);
    chk("rst_y", bus.y_out, 0);
    chk("rst_ovf", bus.ovf_out, 0);
    chk("rst_busy", bus.busy, 0);
    @(negedge clk) async_n = 1'b1;
    lat_chk = 1'b1;
    base = n_out;
    align();
    send(18'h00000);
    send(18'h01000);
    wait_out(base + 2, "t1");
    lat_chk = 1'b0;
    chk("t1_y0", obs_y[base], 18'h00082);
    chk("t1_y1", obs_y[base+1], 18'h00ffd);
    chk("t1_ovf0", obs_ovf[base], 0);
    chk("t1_ovf1", obs_ovf[base+1], 0);

    // 20 random samples with random back-pressure and a 10-cycle hold
    base = n_out;
    align();
    fork
      begin
        for (int i = 0; i < 20; i++) send(rnd_x());
      end
      begin
        for (int i = 0; i < 40; i++) begin
          align();
          bus.out_ready = (i >= 10 && i < 20) ? 1'b0 : 1'($urandom_range(0, 1));
          if (i >= 12 && i < 20) begin
            @(negedge clk);
            chk("t2_blk_vld", bus.out_valid, 1);
            chk("t2_blk_rdy", bus.in_ready, 0);
            if (i == 12) hold_y = bus.y_out;
            else chk("t2_hold_y", bus.y_out, hold_y);
          end
        end
        bus.out_ready = 1'b1;
      end
    join
    wait_out(base + 20, "t2");
    repeat (3) @(negedge clk);
    chk("t2_count", n_out - base, 20);
    chk("t2_sb_empty", sb.size(), 0);

    // overflow on the final add
    write_coef(0, 18'h1ffff);
    write_coef(1, 18'h01000);
    for (int k = 2; k <= DEGREE; k++) write_coef(AW'(k), '0);
    do_swap("t3_swap");
    base = n_out;
    align();
    send(18'h01000);
    wait_out(base + 1, "t3");
    chk("t3_y", obs_y[base], SATURATE ? 32'h1ffff : 32'h20fff);
    chk("t3_ovf", obs_ovf[base], 1);

    // swap while a stream is in flight
    for (int k = 0; k <= DEGREE; k++) write_coef(AW'(k), rnd_c());
    base = n_out;
    fork
      begin
        for (int i = 0; i < 16; i++) send(rnd_x());
      end
      begin
        repeat (6) @(posedge clk);
        do_swap("t4_swap");
      end
      begin
        for (int i = 0; i < 30; i++) begin
          align();
          bus.out_ready = 1'($urandom_range(0, 1));
        end
        bus.out_ready = 1'b1;
      end
    join
    wait_out(base + 16, "t4");
    chk("t4_sb_empty", sb.size(), 0);

    // reset mid-stream with the output blocked
    bus.out_ready = 1'b0;
    align();
    for (int i = 0; i < 4; i++) send(rnd_x());
    repeat (10) @(negedge clk);
    chk("t5_full_vld", bus.out_valid, 1);
    @(posedge clk); #3;
    async_n = 1'b0;
    #1;
    chk("t5_rst_vld", bus.out_valid, 0);
    chk("t5_rst_y", bus.y_out, 0);
    chk("t5_rst_ovf", bus.ovf_out, 0);
    @(negedge clk); @(negedge clk) async_n = 1'b1;
    bus.out_ready = 1'b1;
    base = n_out;
    align();
    send(18'h01000);
    wait_out(base + 1, "t5a");
    chk("t5_bank_init", obs_y[base], 18'h00ffd);

    // reset while a swap is stuck draining
    write_coef(0, 18'h00100);
    bus.out_ready = 1'b0;
    align();
    for (int i = 0; i < 3; i++) send(rnd_x());
    repeat (10) @(negedge clk);
    pulse_swap();
    repeat (3) @(negedge clk);
    chk("t5_drain_busy", bus.busy, 1);
    chk("t5_drain_rdy", bus.in_ready, 0);
    @(posedge clk); #3;
    async_n = 1'b0;
    #1;
    chk("t5_drain_rst_busy", bus.busy, 0);
    chk("t5_drain_rst_vld", bus.out_valid, 0);
    @(negedge clk); @(negedge clk) async_n = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    chk("t5_post_rdy", bus.in_ready, 1);
    do_swap("t5_swap");
    base = n_out;
    align();
    send(18'h01000);
    wait_out(base + 1, "t5b");
    chk("t5_shadow_init", obs_y[base], 18'h00ffd);

    // out-of-range coefficient address is ignored
    write_coef(AW'(DEGREE + 1), 18'h2aaaa);
    do_swap("t6_swap");
    base = n_out;
    align();
    send(18'h01000);
    wait_out(base + 1, "t6");
    chk("t6_y", obs_y[base], 18'h00ffd);
    chk("t6_ovf", obs_ovf[base], 0);

    repeat (5) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
